// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, active-low syncs and gated RGB,
// all registered one clock after the x/y coordinate they belong to.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [3:0]    vga_r_q, vga_r_d;
  logic [3:0]    vga_g_q, vga_g_d;
  logic [3:0]    vga_b_q, vga_b_d;
  logic          vga_hs_q, vga_hs_d;
  logic          vga_vs_q, vga_vs_d;
  logic          frame_start_q, frame_start_d;

  logic h_wrap, v_wrap, h_vis, v_vis, vis, hs_raw, vs_raw;

  // Counter advance, visibility decode, and next values for the output stage
  always_comb begin
    h_wrap        = 1'b0;
    v_wrap        = 1'b0;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_vis         = 1'b0;
    v_vis         = 1'b0;
    vis           = 1'b0;
    hs_raw        = 1'b1;
    vs_raw        = 1'b1;
    x             = '0;
    y             = '0;
    vga_r_d       = 4'h0;
    vga_g_d       = 4'h0;
    vga_b_d       = 4'h0;
    vga_hs_d      = 1'b1;
    vga_vs_d      = 1'b1;
    frame_start_d = 1'b0;

    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + CW'(1);
    end

    h_vis  = (h_cnt_q < H_VIS);
    v_vis  = (v_cnt_q < V_VIS);
    vis    = h_vis && v_vis;
    hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

    if (vis) begin
      x       = h_cnt_q + CW'(1);
      y       = v_cnt_q + CW'(1);
      vga_r_d = {4{color[2]}};
      vga_g_d = {4{color[1]}};
      vga_b_d = {4{color[0]}};
    end

    vga_hs_d      = hs_raw;
    vga_vs_d      = vs_raw;
    frame_start_d = h_wrap && v_wrap;
  end

  // Counters and the single output register stage that keeps sync aligned with RGB
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vga_r_q       <= 4'h0;
      vga_g_q       <= 4'h0;
      vga_b_q       <= 4'h0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-size and a scaled-down instance, both checked every
// cycle against an arithmetic raster model driven by random colours.
module tb_vga_timing;

  localparam int unsigned S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int unsigned S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int unsigned S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int unsigned S_FT = S_HT * S_VT;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        vis;
    logic        hs_n;
    logic        vs_n;
    logic        fs_next;
  } pt_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       fs;
  } regs_t;

  localparam regs_t RST_REGS = regs_t'({12'h000, 3'b110});

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  color;
  logic [11:0] d_x, d_y, s_x, s_y;
  logic [3:0]  d_r, d_g, d_b, s_r, s_g, s_b;
  logic        d_hs, d_vs, d_fs, s_hs, s_vs, s_fs;

  always #5 clk = ~clk;

  vga_timing u_dflt (
    .CLOCK_25(clk), .RESET_N(rst_n), .color(color), .x(d_x), .y(d_y),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
    .frame_start(d_fs)
  );

  vga_timing #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .CLOCK_25(clk), .RESET_N(rst_n), .color(color), .x(s_x), .y(s_y),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .frame_start(s_fs)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    else n_pass++;
  endtask

  // Raster position n clocks after reset release, derived from the timing totals
  function automatic pt_t ref_pt(input int unsigned n,
                                 input int unsigned hv, input int unsigned hf,
                                 input int unsigned hsw, input int unsigned hb,
                                 input int unsigned vv, input int unsigned vf,
                                 input int unsigned vsw, input int unsigned vb);
    pt_t p;
    int unsigned ht, vt, h, v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    p.vis     = (h < hv) && (v < vv);
    p.x       = p.vis ? 12'(h + 1) : 12'd0;
    p.y       = p.vis ? 12'(v + 1) : 12'd0;
    p.hs_n    = !((h >= hv + hf) && (h < hv + hf + hsw));
    p.vs_n    = !((v >= vv + vf) && (v < vv + vf + vsw));
    p.fs_next = (h == ht - 1) && (v == vt - 1);
    return p;
  endfunction

  function automatic regs_t next_regs(input pt_t p, input logic [2:0] c);
    regs_t q;
    q.r  = p.vis ? {4{c[2]}} : 4'h0;
    q.g  = p.vis ? {4{c[1]}} : 4'h0;
    q.b  = p.vis ? {4{c[0]}} : 4'h0;
    q.hs = p.hs_n;
    q.vs = p.vs_n;
    q.fs = p.fs_next;
    return q;
  endfunction

  task automatic check_inst(input string pfx, input logic [11:0] x, input logic [11:0] y,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic hs, input logic vs, input logic fs,
                            input pt_t p, input regs_t e);
    check({pfx, "_x"},  32'(x),  32'(p.x));
    check({pfx, "_y"},  32'(y),  32'(p.y));
    check({pfx, "_r"},  32'(r),  32'(e.r));
    check({pfx, "_g"},  32'(g),  32'(e.g));
    check({pfx, "_b"},  32'(b),  32'(e.b));
    check({pfx, "_hs"}, 32'(hs), 32'(e.hs));
    check({pfx, "_vs"}, 32'(vs), 32'(e.vs));
    check({pfx, "_fs"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_d_x"}, 32'(d_x), 32'd1);
    check({tag, "_d_y"}, 32'(d_y), 32'd1);
    check({tag, "_s_x"}, 32'(s_x), 32'd1);
    check({tag, "_s_y"}, 32'(s_y), 32'd1);
    check({tag, "_d_regs"}, 32'({d_r, d_g, d_b, d_hs, d_vs, d_fs}), 32'(RST_REGS));
    check({tag, "_s_regs"}, 32'({s_r, s_g, s_b, s_hs, s_vs, s_fs}), 32'(RST_REGS));
  endtask

  int unsigned n;
  regs_t       exp_d, exp_s;
  bit          full_mode;
  bit          prev_dhs, have_fall, have_x1, prev_svs, have_vfall, have_fs;
  int unsigned fall_n, x1_n, vfall_n, fs_n, full_cnt;

  task automatic reset_meas();
    n = 0;
    exp_d = RST_REGS;
    exp_s = RST_REGS;
    prev_dhs = 1'b1; have_fall = 1'b0; have_x1 = 1'b0;
    prev_svs = 1'b1; have_vfall = 1'b0; have_fs = 1'b0;
    full_cnt = 0;
  endtask

  // One cycle: compare both instances, take interval measurements, pick next colour
  task automatic step();
    pt_t pd, ps;
    pd = ref_pt(n, 640, 16, 96, 48, 480, 10, 2, 33);
    ps = ref_pt(n, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
    check_inst("d", d_x, d_y, d_r, d_g, d_b, d_hs, d_vs, d_fs, pd, exp_d);
    check_inst("s", s_x, s_y, s_r, s_g, s_b, s_hs, s_vs, s_fs, ps, exp_s);

    if (prev_dhs && !d_hs) begin
      if (have_fall) check("hs_period", 32'(n - fall_n), 32'd800);
      if (have_x1)   check("hs_after_x1", 32'(n - x1_n), 32'd657);
      have_x1   = 1'b0;
      fall_n    = n;
      have_fall = 1'b1;
    end
    if (!prev_dhs && d_hs && have_fall) check("hs_width", 32'(n - fall_n), 32'd96);
    if (d_x == 12'd1) begin
      x1_n    = n;
      have_x1 = 1'b1;
    end
    prev_dhs = d_hs;

    if (prev_svs && !s_vs) begin
      vfall_n    = n;
      have_vfall = 1'b1;
    end
    if (!prev_svs && s_vs && have_vfall) check("vs_width", 32'(n - vfall_n), 32'(2 * S_HT));
    prev_svs = s_vs;

    if (s_fs) begin
      if (have_fs) check("fs_period", 32'(n - fs_n), 32'(S_FT));
      else         check("fs_first", 32'(n), 32'(S_FT));
      if (full_mode) check("rgb_full_count", 32'(full_cnt), 32'(S_HV * S_VV));
      full_cnt = 0;
      fs_n     = n;
      have_fs  = 1'b1;
    end
    if (s_r == 4'hF && s_g == 4'hF && s_b == 4'hF) full_cnt++;

    color = full_mode ? 3'b111 : 3'($urandom);
    exp_d = next_regs(pd, color);
    exp_s = next_regs(ps, color);
  endtask

  initial begin
    rst_n     = 1'b0;
    color     = 3'b000;
    full_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");

    rst_n = 1'b1;
    reset_meas();
    step();
    repeat (2500) begin
      @(negedge clk);
      n++;
      step();
    end

    // Mid-frame reset, asserted away from any clock edge
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    full_mode = 1'b1;
    color     = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");

    rst_n = 1'b1;
    reset_meas();
    step();
    repeat (2000) begin
      @(negedge clk);
      n++;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- CLOCK_25, in, 1, 25 MHz pixel clock; the only clock
- RESET_N, in, 1, asynchronous, active-low reset
- color, in, 3, pixel colour for the current x/y; bit2=R, bit1=G, bit0=B
- x, out, 12, 1-based column (1..640) during visible area; 0 during blanking
- y, out, 12, 1-based row (1..480) during visible lines; 0 during blanking
- vga_r, out, 4, red drive
- vga_g, out, 4, green drive
- vga_b, out, 4, blue drive
- vga_hs, out, 1, horizontal sync, active low
- vga_vs, out, 1, vertical sync, active low
- frame_start, out, 1, one-clock pulse at start of each frame

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=800), incrementing every CLOCK_25 rising edge, and wrap to 0.
REQ-004 v_cnt SHALL count 0..V_TOTAL-1 (V_TOTAL=525), increment only on the clock where h_cnt wraps 799->0, and wrap 524->0 on that same clock.
REQ-005 h_vis SHALL be (h_cnt < H_VISIBLE); v_vis SHALL be (v_cnt < V_VISIBLE); vis SHALL be h_vis AND v_vis.
REQ-006 x SHALL be combinational: h_cnt+1 when vis, else 0. y SHALL be v_cnt+1 when vis, else 0. All arithmetic is 12-bit, with no overflow possible.
REQ-007 hs_raw SHALL be low for h_cnt in [656, 751] (H_VISIBLE+H_FRONT .. +H_SYNC-1), else high.
REQ-008 vs_raw SHALL be low for v_cnt in [490, 491], else high, for the whole line duration.
REQ-009 color SHALL be sampled on the same edge that advances the counters past the current x/y; the pipeline latency from x/y to vga_r/g/b is exactly 1 clock.
REQ-010 vga_hs and vga_vs SHALL be hs_raw/vs_raw registered once, so sync stays aligned with RGB.
REQ-011 When vis was 1 in the previous cycle, each RGB channel SHALL be its colour bit replicated to 4 bits (e.g. color=3'b010 -> r=0, g=4'hF, b=0).
REQ-012 When vis was 0 in the previous cycle, vga_r, vga_g and vga_b SHALL be 0 regardless of color.
REQ-013 frame_start SHALL be a registered pulse, high for exactly one clock, asserted in the cycle after h_cnt=799 and v_cnt=524 (i.e. aligned with the first output of pixel x=1, y=1).
REQ-014 Non-default parameter values SHALL scale all thresholds consistently; totals SHALL NOT exceed 4095.

Reset
REQ-015 While RESET_N=0, regardless of clock, the module SHALL hold h_cnt=0, v_cnt=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_start=0.
REQ-016 During reset, x=1 and y=1, since the counters sit at the first visible pixel.
REQ-017 On the first rising edge after RESET_N deasserts, counting SHALL resume from h_cnt=0, v_cnt=0.
REQ-018 Reset asserted mid-frame SHALL immediately force the REQ-015 values, with no partial-line completion.

Verification
REQ-019 Release reset, then count clocks between vga_hs falling edges -> exactly 800; low width 96 clocks; falling edge 657 clocks after the first visible RGB output.
REQ-020 Run 2 frames -> vga_vs low for exactly 1600 clocks (2 lines) per frame; frame_start pulses exactly every 420000 clocks.
REQ-021 Drive color = {x[0],y[0],1'b1} -> RGB at cycle t+1 matches the x/y of cycle t; RGB = 0 whenever x or y was 0.
REQ-022 Check x/y boundaries -> x steps 1..640 then 0 for 160 clocks; y=480 on the last visible line; y=0 on lines 480..524.
REQ-023 Assert RESET_N=0 for 3 clocks at h_cnt=300, v_cnt=200 -> outputs take reset values asynchronously; after release x=1, y=1 and the next frame_start arrives 420000 clocks later.
REQ-024 Hold color=3'b111 constant -> RGB = 4'hF on exactly 307200 clocks per frame.
